// File: rtl/btle_tx_defs.sv
// Shared BLE TX-chain definitions: default widths, air-bit pacing and the
// serializer FSM encoding.
package btle_tx_defs;

  localparam int unsigned BTLE_CRC_STATE_BIT_WIDTH = 24;
  localparam int unsigned BTLE_BIT_PERIOD_CLK      = 16;
  localparam int unsigned BTLE_MAX_PDU_BYTE        = 257;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/btle_pdu_bit_serializer.sv
// PDU bit serializer feeding crc24: accepts header+payload bytes over a
// valid/ready stream and emits them LSB-first, one bit per BIT_PERIOD_CLK
// clocks, with a CRC init load strobe before the first bit and a last-bit flag.
module btle_pdu_bit_serializer
  import btle_tx_defs::*;
#(
  parameter int unsigned CRC_STATE_BIT_WIDTH = BTLE_CRC_STATE_BIT_WIDTH,
  parameter int unsigned BIT_PERIOD_CLK      = BTLE_BIT_PERIOD_CLK,
  parameter int unsigned LEN_BIT_WIDTH       = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_BIT_WIDTH-1:0]       pdu_len_byte,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit_in,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_in_valid,
  output logic                           byte_in_ready,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  output logic                           crc_state_init_bit_load,
  output logic                           info_bit,
  output logic                           info_bit_valid,
  output logic                           info_bit_valid_last,
  output logic                           busy,
  output logic                           err_underrun
);

  localparam int unsigned CntW    = (BIT_PERIOD_CLK > 2) ? $clog2(BIT_PERIOD_CLK) : 1;
  localparam int unsigned BitCntW = LEN_BIT_WIDTH + 3;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_PERIOD_CLK - 1);

  ser_state_e                     state_q, state_d;
  logic [LEN_BIT_WIDTH-1:0]       len_q, len_d;
  logic [LEN_BIT_WIDTH-1:0]       acc_q, acc_d;
  logic [7:0]                     hold_q, hold_d;
  logic                           hold_full_q, hold_full_d;
  logic [7:0]                     shift_q, shift_d;
  logic [2:0]                     bit_in_byte_q, bit_in_byte_d;
  logic [BitCntW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] init_q, init_d;
  logic                           load_q, load_d;
  logic                           info_bit_q, info_bit_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic                           busy_q, busy_d;
  logic                           err_q, err_d;
  logic                           ready_q, ready_d;

  logic               accept;
  logic               emit;
  logic [BitCntW-1:0] last_idx;

  // ready_q already implies an empty holding register, so accept never
  // collides with the consume at a byte boundary.
  assign accept   = byte_in_valid && ready_q;
  assign last_idx = {len_q, 3'b000} - BitCntW'(1);

  // Next-state logic for FSM, pacing, byte intake and all registered outputs.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    acc_d         = acc_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    bit_in_byte_d = bit_in_byte_q;
    bit_cnt_d     = bit_cnt_q;
    cnt_d         = cnt_q;
    init_d        = init_q;
    load_d        = 1'b0;
    info_bit_d    = info_bit_q;
    valid_d       = 1'b0;
    last_d        = 1'b0;
    busy_d        = busy_q;
    err_d         = err_q;
    emit          = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start && (pdu_len_byte != '0)) begin
          state_d       = StLoad;
          len_d         = pdu_len_byte;
          init_d        = crc_state_init_bit_in;
          err_d         = 1'b0;
          load_d        = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = '0;
          acc_d         = '0;
          hold_full_d   = 1'b0;
          bit_in_byte_d = '0;
          bit_cnt_d     = '0;
        end
      end

      StLoad: begin
        cnt_d   = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        state_d = StRun;
      end

      StRun: begin
        // Last bit or underrun was flagged last cycle: wind down to idle.
        if (last_q || err_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
          // Decide one cycle early so the registered strobe lands on the slot.
          if (cnt_d == CntMax) begin
            if (bit_in_byte_q == 3'd0) begin
              if (hold_full_q) begin
                info_bit_d  = hold_q[0];
                shift_d     = {1'b0, hold_q[7:1]};
                hold_full_d = 1'b0;
                emit        = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              info_bit_d = shift_q[0];
              shift_d    = {1'b0, shift_q[7:1]};
              emit       = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (emit) begin
      valid_d       = 1'b1;
      last_d        = (bit_cnt_q == last_idx);
      bit_in_byte_d = bit_in_byte_q + 3'd1;
      bit_cnt_d     = bit_cnt_q + BitCntW'(1);
    end

    if (accept && (state_q != StIdle)) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
      acc_d       = acc_q + LEN_BIT_WIDTH'(1);
    end

    ready_d = busy_d && !hold_full_d && (acc_d < len_d);
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= '0;
      acc_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      bit_in_byte_q <= '0;
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      init_q        <= '0;
      load_q        <= 1'b0;
      info_bit_q    <= 1'b0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      acc_q         <= acc_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      bit_in_byte_q <= bit_in_byte_d;
      bit_cnt_q     <= bit_cnt_d;
      cnt_q         <= cnt_d;
      init_q        <= init_d;
      load_q        <= load_d;
      info_bit_q    <= info_bit_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      ready_q       <= ready_d;
    end
  end

  assign byte_in_ready           = ready_q;
  assign crc_state_init_bit      = init_q;
  assign crc_state_init_bit_load = load_q;
  assign info_bit                = info_bit_q;
  assign info_bit_valid          = valid_q;
  assign info_bit_valid_last     = last_q;
  assign busy                    = busy_q;
  assign err_underrun            = err_q;

endmodule

// File: tb/tb_btle_pdu_bit_serializer.sv
// Directed bench for btle_pdu_bit_serializer: timing of load/bit/last strobes,
// underrun, ignore rules, asynchronous abort and a maximum-length packet.
module tb_btle_pdu_bit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  pdu_len_byte = '0;
  logic [23:0] crc_state_init_bit_in = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_ready;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_bit_load;
  logic        info_bit;
  logic        info_bit_valid;
  logic        info_bit_valid_last;
  logic        busy;
  logic        err_underrun;

  btle_pdu_bit_serializer dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .pdu_len_byte            (pdu_len_byte),
    .crc_state_init_bit_in   (crc_state_init_bit_in),
    .byte_in                 (byte_in),
    .byte_in_valid           (byte_in_valid),
    .byte_in_ready           (byte_in_ready),
    .crc_state_init_bit      (crc_state_init_bit),
    .crc_state_init_bit_load (crc_state_init_bit_load),
    .info_bit                (info_bit),
    .info_bit_valid          (info_bit_valid),
    .info_bit_valid_last     (info_bit_valid_last),
    .busy                    (busy),
    .err_underrun            (err_underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] feed[$];
  logic [7:0] exp_b[$];

  // Per-packet observations; k counts cycles after the start cycle T.
  int          n_strobe, n_last, last_k, last_no, first_k, gap_bad, n_load, load_k;
  int          busy_fall_k, err_k, n_acc, bit_err, orphan;
  logic        was_busy, err_at_load;
  logic [23:0] init_at_load;
  logic [63:0] bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; keeps byte_in_valid asserted while the feed queue has data.
  task automatic tick();
    logic xfer;
    xfer = byte_in_valid && byte_in_ready;
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(feed.pop_front());
      n_acc++;
    end
    byte_in_valid = (feed.size() > 0);
    byte_in       = (feed.size() > 0) ? feed[0] : 8'h00;
  endtask

  task automatic run_pkt(input int len, input logic [23:0] init, input int ncyc,
                         input int mid_k, input int rst_k);
    int         prev_k;
    logic [7:0] eb;
    n_strobe = 0; n_last = 0; last_k = -1; last_no = -1; first_k = -1; gap_bad = 0;
    n_load = 0; load_k = -1; busy_fall_k = -1; err_k = -1; n_acc = 0; bit_err = 0;
    orphan = 0; was_busy = 1'b0; err_at_load = 1'b1; init_at_load = '0; bits = '0;
    prev_k = 0;
    exp_b = feed;
    byte_in_valid = (feed.size() > 0);
    byte_in       = (feed.size() > 0) ? feed[0] : 8'h00;
    start                 = 1'b1;
    pdu_len_byte          = 9'(len);
    crc_state_init_bit_in = init;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      start = (k == mid_k);
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs",
              {byte_in_ready, crc_state_init_bit, crc_state_init_bit_load, info_bit,
               info_bit_valid, info_bit_valid_last, busy, err_underrun}, 32'd0);
      end
      if (rst_k > 0 && k == rst_k + 3) rst = 1'b0;
      if (crc_state_init_bit_load) begin
        n_load++;
        load_k       = k;
        init_at_load = crc_state_init_bit;
        err_at_load  = err_underrun;
      end
      if (info_bit_valid) begin
        if (n_strobe > 0 && (k - prev_k) != 16) gap_bad++;
        if (n_strobe == 0) first_k = k;
        if (n_strobe < 64) bits[n_strobe] = info_bit;
        if (n_strobe < exp_b.size() * 8) begin
          eb = exp_b[n_strobe / 8];
          if (info_bit !== eb[n_strobe % 8]) bit_err++;
        end
        n_strobe++;
        prev_k = k;
        if (info_bit_valid_last) begin
          n_last++;
          last_k  = k;
          last_no = n_strobe;
        end
      end else if (info_bit_valid_last) begin
        orphan++;
      end
      if (busy) was_busy = 1'b1;
      else if (was_busy && busy_fall_k < 0) busy_fall_k = k;
      if (err_underrun && err_k < 0) err_k = k;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_outputs",
          {byte_in_ready, crc_state_init_bit, crc_state_init_bit_load, info_bit,
           info_bit_valid, info_bit_valid_last, busy, err_underrun}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: single byte 0xA5
    feed.delete(); feed.push_back(8'hA5);
    run_pkt(1, 24'h555555, 140, -1, -1);
    check("t1_load_cycle", load_k, 1);
    check("t1_load_count", n_load, 1);
    check("t1_init_value", init_at_load, 24'h555555);
    check("t1_init_held", crc_state_init_bit, 24'h555555);
    check("t1_first_bit_cycle", first_k, 16);
    check("t1_strobes", n_strobe, 8);
    check("t1_bits", bits[7:0], 8'hA5);
    check("t1_last_cycle", last_k, 128);
    check("t1_last_count", n_last, 1);
    check("t1_busy_fall", busy_fall_k, 129);
    check("t1_gaps", gap_bad, 0);

    // 2: three bytes, extra bytes offered beyond len
    feed.delete();
    feed.push_back(8'h01); feed.push_back(8'h80); feed.push_back(8'hFF);
    feed.push_back(8'hAA); feed.push_back(8'hBB);
    run_pkt(3, 24'h123456, 400, -1, -1);
    check("t2_strobes", n_strobe, 24);
    check("t2_bits", bits[23:0], 24'hFF8001);
    check("t2_last_no", last_no, 24);
    check("t2_last_count", n_last, 1);
    check("t2_gaps", gap_bad, 0);
    check("t2_accepts", n_acc, 3);
    check("t2_orphan_last", orphan, 0);

    // 3: underrun after one of two bytes
    feed.delete(); feed.push_back(8'h0F);
    run_pkt(2, 24'h000001, 160, -1, -1);
    check("t3_strobes", n_strobe, 8);
    check("t3_bits", bits[7:0], 8'h0F);
    check("t3_no_last", n_last + orphan, 0);
    check("t3_err_cycle", err_k, 144);
    check("t3_busy_fall", busy_fall_k, 145);
    check("t3_err_sticky", err_underrun, 1);

    // 3b: next start clears err_underrun
    feed.delete(); feed.push_back(8'h5A);
    run_pkt(1, 24'hABCDEF, 140, -1, -1);
    check("t3b_err_cleared", err_at_load, 0);
    check("t3b_bit_errors", bit_err, 0);
    check("t3b_strobes", n_strobe, 8);

    // 4a: zero length start is ignored
    feed.delete();
    run_pkt(0, 24'h777777, 20, -1, -1);
    check("t4a_no_load", n_load, 0);
    check("t4a_never_busy", was_busy, 0);
    check("t4a_init_kept", crc_state_init_bit, 24'hABCDEF);

    // 4b: start mid-packet is ignored
    feed.delete(); feed.push_back(8'h12); feed.push_back(8'h34);
    run_pkt(2, 24'h0F0F0F, 270, 40, -1);
    check("t4b_load_count", n_load, 1);
    check("t4b_strobes", n_strobe, 16);
    check("t4b_bits", bits[15:0], 16'h3412);
    check("t4b_last_count", n_last, 1);

    // 5: asynchronous reset between bit 5 (k=80) and bit 6 (k=96)
    feed.delete(); feed.push_back(8'hC3); feed.push_back(8'h99);
    run_pkt(2, 24'h111111, 100, -1, 88);
    check("t5_strobes_before_abort", n_strobe, 5);
    check("t5_no_last", n_last + orphan, 0);
    feed.delete(); feed.push_back(8'h3C);
    run_pkt(1, 24'h222222, 140, -1, -1);
    check("t5_post_bits", bits[7:0], 8'h3C);
    check("t5_post_last_cycle", last_k, 128);
    check("t5_post_load", n_load, 1);

    // 6: maximum length packet, 257 random bytes
    feed.delete();
    for (int i = 0; i < 257; i++) feed.push_back(8'($urandom_range(0, 255)));
    run_pkt(257, 24'h555555, 257 * 128 + 10, -1, -1);
    check("t6_strobes", n_strobe, 2056);
    check("t6_last_no", last_no, 2056);
    check("t6_last_count", n_last, 1);
    check("t6_bit_errors", bit_err, 0);
    check("t6_gaps", gap_bad, 0);
    check("t6_accepts", n_acc, 257);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
